mem_bus_arbiter: RTL and testbench

Shares the single 16x32 RAM port between the instruction-fetch path (PC-driven) and the data path (MemoryController LDR/STR traffic). It replaces the combinational address-bus mux with a registered, request/grant arbiter. Data accesses have priority, and a bounded-wait counter guarantees fetch progress. It sits between the CPU sequencer and memory controller on one side and the RAM on the other.

---
 rtl/cpu_mem_pkg.sv | 17 +
 rtl/mem_arb_starve_ctr.sv | 40 ++++
 rtl/mem_bus_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory-port arbiter: state encoding,
// default bus widths and the RAM write-strobe polarity.
package cpu_mem_pkg;

    localparam int AW_DEF     = 16;
    localparam int DW_DEF     = 32;
    localparam int WAIT_CNT_W = 4;

    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC_I = 2'd1,
        ACC_D = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of arbitrations the fetch port has lost in a row; flags
// starvation so fetch can override the data port's priority.
module mem_arb_starve_ctr
    import cpu_mem_pkg::*;
#(
    parameter int MAX_WAIT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    input  logic req_i,
    output logic starved_o
);

    localparam logic [WAIT_CNT_W-1:0] MAX_Q = WAIT_CNT_W'(MAX_WAIT);

    logic [WAIT_CNT_W-1:0] cnt_q;
    logic [WAIT_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX_Q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign starved_o = (cnt_q == MAX_Q) && req_i;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Registered request/grant arbiter sharing one RAM port between instruction
// fetch and data load/store; data has priority, bounded by a starvation counter.
module mem_bus_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int MAX_WAIT = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_rw,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    arb_state_e    state_q;
    arb_state_e    state_d;
    logic          busy_q;
    logic          if_gnt_q;
    logic          d_gnt_q;
    logic          if_rvalid_q;
    logic          d_rvalid_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] d_rdata_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          mem_rw_q;

    logic          starved;
    logic          cnt_inc;
    logic          cnt_clr;

    mem_arb_starve_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (cnt_clr),
        .inc_i     (cnt_inc),
        .req_i     (if_req),
        .starved_o (starved)
    );

    // Arbitration happens only in IDLE; every access lasts exactly one cycle.
    always_comb begin
        state_d = IDLE;
        if (state_q == IDLE) begin
            if (d_req && !starved) begin
                state_d = ACC_D;
            end else if (if_req) begin
                state_d = ACC_I;
            end
        end
    end

    assign cnt_inc = (state_d == ACC_D) && if_req;
    assign cnt_clr = (state_q == IDLE) && (!if_req || (state_d == ACC_I));

    // The RAM-side registers double as the grant-edge latches of the winner.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_rw_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= (state_d != IDLE);
            if_gnt_q    <= (state_d == ACC_I);
            d_gnt_q     <= (state_d == ACC_D);
            if_rvalid_q <= (state_q == ACC_I);
            d_rvalid_q  <= (state_q == ACC_D);
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_rw_q    <= 1'b0;
            case (state_d)
                ACC_D: begin
                    mem_addr_q  <= d_addr;
                    mem_wdata_q <= d_wdata;
                    mem_rw_q    <= (d_we == RW_WRITE);
                end
                ACC_I: begin
                    mem_addr_q <= if_addr;
                end
                default: ;
            endcase
            if (state_q == ACC_I) begin
                if_rdata_q <= mem_rdata;
            end
            if ((state_q == ACC_D) && (mem_rw_q != RW_WRITE)) begin
                d_rdata_q <= mem_rdata;
            end
        end
    end

    assign busy      = busy_q;
    assign if_gnt    = if_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_rw    = mem_rw_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a 16x32 behavioural RAM attached.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rw;
    logic [31:0] mem_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int rw_cnt = 0;

    logic [31:0] ram [16] = '{
        32'h1111_1111, 32'h2222_2222, 32'h0000_0000, 32'h3333_3333,
        32'h0000_0000, 32'hE1A0_0001, 32'h0000_0000, 32'h0000_0000,
        32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
        32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000
    };

    mem_bus_arbiter #(
        .AW       (16),
        .DW       (32),
        .MAX_WAIT (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rw    (mem_rw),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr[3:0]];

    always @(posedge clk) begin
        if (mem_rw) begin
            ram[mem_addr[3:0]] <= mem_wdata;
            rw_cnt <= rw_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag, input logic [31:0] exp_if_rdata,
                                      input logic [31:0] exp_d_rdata);
        check({tag, "_if_gnt"}, 32'(if_gnt), 32'd0);
        check({tag, "_d_gnt"}, 32'(d_gnt), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_mem_rw"}, 32'(mem_rw), 32'd0);
        check({tag, "_if_rdata"}, if_rdata, exp_if_rdata);
        check({tag, "_d_rdata"}, d_rdata, exp_d_rdata);
    endtask

    initial begin
        rst     = 1'b0;
        if_req  = 1'b0;
        if_addr = 16'h0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = 16'h0;
        d_wdata = 32'h0;

        // Power-on reset
        tick();
        tick();
        check_idle_outputs("por", 32'h0, 32'h0);
        check("por_if_rvalid", 32'(if_rvalid), 32'd0);
        check("por_d_rvalid", 32'(d_rvalid), 32'd0);
        rst = 1'b1;
        tick();

        // Lone fetch of RAM[5]
        check("lf_busy_c0", 32'(busy), 32'd0);
        if_req  = 1'b1;
        if_addr = 16'h0005;
        tick();
        check("lf_if_gnt", 32'(if_gnt), 32'd1);
        check("lf_d_gnt", 32'(d_gnt), 32'd0);
        check("lf_mem_addr", 32'(mem_addr), 32'h5);
        check("lf_mem_rw", 32'(mem_rw), 32'd0);
        check("lf_busy_c1", 32'(busy), 32'd1);
        if_req = 1'b0;
        tick();
        check("lf_if_rvalid", 32'(if_rvalid), 32'd1);
        check("lf_if_rdata", if_rdata, 32'hE1A0_0001);
        check("lf_if_gnt_c2", 32'(if_gnt), 32'd0);
        check("lf_mem_addr_c2", 32'(mem_addr), 32'd0);
        check("lf_busy_c2", 32'(busy), 32'd0);

        // Store then back-to-back load of address 0xA
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 16'h000A;
        d_wdata = 32'hDEAD_BEEF;
        tick();
        check("st_d_gnt", 32'(d_gnt), 32'd1);
        check("st_mem_rw", 32'(mem_rw), 32'd1);
        check("st_mem_addr", 32'(mem_addr), 32'hA);
        check("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        d_we    = 1'b0;
        d_wdata = 32'h0;
        tick();
        check("st_d_rvalid", 32'(d_rvalid), 32'd1);
        check("st_d_rdata_kept", d_rdata, 32'h0);
        check("st_mem_rw_off", 32'(mem_rw), 32'd0);
        tick();
        check("ld_d_gnt", 32'(d_gnt), 32'd1);
        check("ld_mem_rw", 32'(mem_rw), 32'd0);
        check("ld_mem_addr", 32'(mem_addr), 32'hA);
        d_req = 1'b0;
        tick();
        check("ld_d_rvalid", 32'(d_rvalid), 32'd1);
        check("ld_d_rdata", d_rdata, 32'hDEAD_BEEF);
        check("ld_if_rdata_kept", if_rdata, 32'hE1A0_0001);
        check("ld_rw_count", 32'(rw_cnt), 32'd1);

        // Contention: both requesters held, MAX_WAIT = 3
        if_req  = 1'b1;
        if_addr = 16'h0001;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 16'h0003;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("ct_d_gnt_%0d", i), 32'(d_gnt), 32'((i % 4) != 3));
            check($sformatf("ct_if_gnt_%0d", i), 32'(if_gnt), 32'((i % 4) == 3));
            tick();
            check($sformatf("ct_busy_%0d", i), 32'(busy), 32'd0);
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        check("ct_if_rdata", if_rdata, 32'h2222_2222);
        check("ct_d_rdata", d_rdata, 32'h3333_3333);
        tick();

        // Withdrawal: data request raised in ACC_I, dropped before arbitration
        if_req  = 1'b1;
        if_addr = 16'h0000;
        tick();
        check("wd_if_gnt", 32'(if_gnt), 32'd1);
        if_req  = 1'b0;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 16'h0007;
        d_wdata = 32'hBAD0_BAD0;
        tick();
        check("wd_if_rvalid", 32'(if_rvalid), 32'd1);
        check("wd_if_rdata", if_rdata, 32'h1111_1111);
        d_req = 1'b0;
        d_we  = 1'b0;
        tick();
        check("wd_d_gnt", 32'(d_gnt), 32'd0);
        check("wd_mem_rw", 32'(mem_rw), 32'd0);
        check("wd_busy", 32'(busy), 32'd0);
        tick();
        check("wd_ram7", ram[7], 32'h0);
        check("wd_rw_count", 32'(rw_cnt), 32'd1);

        // Back-to-back fetches of 0x0 and 0x1
        check("bb_busy_c0", 32'(busy), 32'd0);
        if_req  = 1'b1;
        if_addr = 16'h0000;
        tick();
        check("bb_gnt_c1", 32'(if_gnt), 32'd1);
        check("bb_busy_c1", 32'(busy), 32'd1);
        if_addr = 16'h0001;
        tick();
        check("bb_rvalid_c2", 32'(if_rvalid), 32'd1);
        check("bb_rdata_c2", if_rdata, 32'h1111_1111);
        check("bb_busy_c2", 32'(busy), 32'd0);
        tick();
        check("bb_gnt_c3", 32'(if_gnt), 32'd1);
        check("bb_addr_c3", 32'(mem_addr), 32'h1);
        check("bb_busy_c3", 32'(busy), 32'd1);
        if_req = 1'b0;
        tick();
        check("bb_rvalid_c4", 32'(if_rvalid), 32'd1);
        check("bb_rdata_c4", if_rdata, 32'h2222_2222);
        check("bb_busy_c4", 32'(busy), 32'd0);
        tick();

        // Asynchronous reset in the middle of a store
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 16'h0009;
        d_wdata = 32'hCAFE_F00D;
        tick();
        check("rs_d_gnt", 32'(d_gnt), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_idle_outputs("rs", 32'h0, 32'h0);
        check("rs_if_rvalid", 32'(if_rvalid), 32'd0);
        check("rs_d_rvalid", 32'(d_rvalid), 32'd0);
        tick();
        check("rs_ram9", ram[9], 32'h0);
        rst = 1'b1;
        tick();
        check("rs_no_rvalid", 32'(d_rvalid), 32'd0);
        check("rs_regrant", 32'(d_gnt), 32'd1);
        check("rs_regrant_rw", 32'(mem_rw), 32'd1);
        d_req = 1'b0;
        d_we  = 1'b0;
        tick();
        check("rs_rvalid", 32'(d_rvalid), 32'd1);
        check("rs_d_rdata", d_rdata, 32'h0);
        check("rs_ram9_written", ram[9], 32'hCAFE_F00D);
        check("rs_rw_count", 32'(rw_cnt), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
